// File: rtl/flac_pkg.sv
// Shared definitions for the FLAC fixed-predictor decoder: FSM states,
// field widths and the zig-zag residual mapping.
package flac_pkg;

  localparam int RICE_PARAM_W = 4;
  localparam int SAMPLE_W     = 16;
  localparam int PRED_ORDER   = 2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PARAM,
    ST_WARMUP,
    ST_UNARY,
    ST_BINARY,
    ST_RECON,
    ST_DONE
  } decState_e;

  // Even codes map to non-negative residuals, odd codes to negative ones;
  // -((u+1)>>1) for odd u is the bitwise complement of u>>1.
  function automatic logic [31:0] zigzagDecode(input logic [31:0] u);
    return u[0] ? ~(u >> 1) : (u >> 1);
  endfunction

endpackage

// File: rtl/flac_fixed_decoder_bit_reader.sv
// MSB-first bit reader over 16-bit words: one bit per consume, the word
// address advances as the last bit of a word is taken, without a stall.
module flac_bit_reader #(
  parameter int ADDR_W = 16
) (
  input  logic              iClock,
  input  logic              iReset,
  input  logic [ADDR_W-1:0] addressStart,
  input  logic [15:0]       word,
  input  logic              consume,
  output logic [ADDR_W-1:0] address,
  output logic              bitValue
);

  logic [3:0] pos;

  // NOTE: flops use non-blocking assignment so pos and address both update from pre-edge values.
  always_ff @(posedge iClock) begin
    if (iReset) begin
      address <= addressStart;
      pos     <= 4'd0;
    end else if (consume) begin
      pos <= pos + 4'd1;
      if (pos == 4'd15) begin
        address <= address + ADDR_W'(1);
      end
    end
  end

  assign bitValue = word[4'd15 - pos];

endmodule

// File: rtl/flac_fixed_decoder.sv
// Streaming FLAC subframe decoder with order-2 fixed prediction.
// Define FLAC_DEC_ERR_CHECK_EN to add the sticky oError flag for runaway unary codes.
module flac_fixed_decoder
  import flac_pkg::*;
#(
  parameter int ADDR_W = 16
`ifdef FLAC_DEC_ERR_CHECK_EN
  ,
  parameter int MAX_Q  = 31
`endif
) (
  input  logic              iClock,
  input  logic              iReset,
  input  logic [15:0]       numSamples,
  input  logic [ADDR_W-1:0] iAddressStart,
  output logic [ADDR_W-1:0] iAddress,
  input  logic [15:0]       iMemory,
  input  logic [ADDR_W-1:0] oAddressStart,
  output logic [ADDR_W-1:0] oAddress,
  output logic [15:0]       oSample,
  output logic              oWrite,
  output logic              done
`ifdef FLAC_DEC_ERR_CHECK_EN
  ,
  output logic              oError
`endif
);

  decState_e state, nextState;

  logic                    consume;
  logic                    bitValue;
  logic [3:0]              bitCnt;
  logic [RICE_PARAM_W-1:0] kReg;
  logic [15:0]             numReg;
  logic [15:0]             remaining;
  logic [15:0]             qCnt;
  logic [14:0]             lsbs;
  logic [SAMPLE_W-2:0]     warmShift;
  logic                    warmIdx;
  logic                    warmWrite;
  logic                    warmLast;
  logic                    qOverflow;
  logic [SAMPLE_W-1:0]     warmSample;
  logic [SAMPLE_W-1:0]     s1, s2;
  logic [SAMPLE_W-1:0]     outSample;
  logic [SAMPLE_W-1:0]     reconSample;
  logic [31:0]             uValue;
  logic [18:0]             s1Ext, s2Ext, residual;

  flac_bit_reader #(.ADDR_W(ADDR_W)) u_reader (
    .iClock       (iClock),
    .iReset       (iReset),
    .addressStart (iAddressStart),
    .word         (iMemory),
    .consume      (consume),
    .address      (iAddress),
    .bitValue     (bitValue)
  );

  assign warmSample = {warmShift, bitValue};
  assign warmLast   = (bitCnt == 4'd15) && (warmIdx || (numReg == 16'd1));

  // Residual reconstruction; 19 bits hold 2*s1 - s2 + r before the 16-bit wrap.
  assign uValue      = ({16'd0, qCnt} << kReg) | {17'd0, lsbs};
  assign residual    = 19'(zigzagDecode(uValue));
  assign s1Ext       = {{3{s1[15]}}, s1};
  assign s2Ext       = {{3{s2[15]}}, s2};
  assign reconSample = 16'((s1Ext << 1) - s2Ext + residual);

`ifdef FLAC_DEC_ERR_CHECK_EN
  assign qOverflow = (qCnt == 16'(MAX_Q));
`else
  assign qOverflow = 1'b0;
`endif

  always_ff @(posedge iClock) begin
    if (iReset) state <= ST_IDLE;
    else        state <= nextState;
  end

  // NOTE: every combinational output is defaulted first so no latch is inferred.
  always_comb begin
    nextState = state;
    unique case (state)
      ST_IDLE:   nextState = (numReg == 16'd0) ? ST_DONE : ST_PARAM;
      ST_PARAM:  if (bitCnt == 4'd3) nextState = ST_WARMUP;
      ST_WARMUP: if (warmLast) nextState = (numReg <= 16'(PRED_ORDER)) ? ST_DONE : ST_UNARY;
      ST_UNARY: begin
        if (bitValue)       nextState = (kReg == '0) ? ST_RECON : ST_BINARY;
        else if (qOverflow) nextState = ST_DONE;
      end
      ST_BINARY: if (bitCnt == 4'(kReg - 4'd1)) nextState = ST_RECON;
      ST_RECON:  nextState = (remaining == 16'd1) ? ST_DONE : ST_UNARY;
      ST_DONE:   nextState = ST_DONE;
      default:   nextState = ST_IDLE;
    endcase
  end

  always_comb begin
    consume = (state == ST_PARAM) || (state == ST_WARMUP) ||
              (state == ST_UNARY) || (state == ST_BINARY);
    oWrite  = warmWrite || (state == ST_RECON);
    oSample = (state == ST_RECON) ? reconSample : outSample;
    // A warm-up write lands in the first DONE cycle, so done waits one more.
    done    = (state == ST_DONE) && !warmWrite;
  end

  always_ff @(posedge iClock) begin
    if (iReset) begin
      numReg    <= numSamples;
      bitCnt    <= 4'd0;
      kReg      <= '0;
      remaining <= 16'd0;
      qCnt      <= 16'd0;
      lsbs      <= 15'd0;
      warmShift <= '0;
      warmIdx   <= 1'b0;
      warmWrite <= 1'b0;
      s1        <= '0;
      s2        <= '0;
      outSample <= '0;
      oAddress  <= oAddressStart;
    end else begin
      bitCnt    <= (state != nextState) ? 4'd0 : bitCnt + 4'd1;
      warmWrite <= (state == ST_WARMUP) && (bitCnt == 4'd15);

      unique case (state)
        ST_IDLE:   remaining <= numReg - 16'(PRED_ORDER);
        ST_PARAM:  kReg <= {kReg[RICE_PARAM_W-2:0], bitValue};
        ST_WARMUP: begin
          warmShift <= {warmShift[SAMPLE_W-3:0], bitValue};
          if (bitCnt == 4'd15) warmIdx <= 1'b1;
        end
        ST_UNARY:  if (!bitValue) qCnt <= qCnt + 16'd1;
        ST_BINARY: lsbs <= {lsbs[13:0], bitValue};
        ST_RECON: begin
          qCnt      <= 16'd0;
          lsbs      <= 15'd0;
          remaining <= remaining - 16'd1;
        end
        default: ;
      endcase

      if ((state == ST_WARMUP) && (bitCnt == 4'd15)) begin
        outSample <= warmSample;
        s1        <= warmSample;
        s2        <= s1;
      end else if (state == ST_RECON) begin
        outSample <= reconSample;
        s1        <= reconSample;
        s2        <= s1;
      end

      if (oWrite) oAddress <= oAddress + ADDR_W'(1);
    end
  end

`ifdef FLAC_DEC_ERR_CHECK_EN
  always_ff @(posedge iClock) begin
    if (iReset) oError <= 1'b0;
    else if ((state == ST_UNARY) && !bitValue && qOverflow) oError <= 1'b1;
  end
`endif

endmodule

// File: tb/tb_flac_fixed_decoder.sv
// Scoreboard bench for flac_fixed_decoder: a reference encoder builds each
// stream and predicts every write (data, address, cycle) plus done timing.
module tb_flac_fixed_decoder;

  localparam int MAX_Q_TB = 31;

  logic        iClock = 1'b0;
  logic        iReset = 1'b1;
  logic [15:0] numSamples = 16'd0;
  logic [15:0] iAddressStart = 16'd0;
  logic [15:0] oAddressStart = 16'd0;
  logic [15:0] iAddress, oAddress, iMemory, oSample;
  logic        oWrite, done;
`ifdef FLAC_DEC_ERR_CHECK_EN
  logic        oError;
`endif

  logic [15:0] mem [0:65535];
  assign iMemory = mem[iAddress];

  always #5 iClock = ~iClock;

  flac_fixed_decoder dut (
    .iClock        (iClock),
    .iReset        (iReset),
    .numSamples    (numSamples),
    .iAddressStart (iAddressStart),
    .iAddress      (iAddress),
    .iMemory       (iMemory),
    .oAddressStart (oAddressStart),
    .oAddress      (oAddress),
    .oSample       (oSample),
    .oWrite        (oWrite),
    .done          (done)
`ifdef FLAC_DEC_ERR_CHECK_EN
    ,
    .oError        (oError)
`endif
  );

  typedef struct {
    logic [15:0] addr;
    logic [15:0] data;
    int          cyc;
  } wr_t;

  wr_t plan[$];
  wr_t sb[$];
  bit  bits[$];
  int  uq[$];
  int  total = 0;
  int  bad = 0;
  int  cyc = 0;
  int  doneCycle = -1;
  int  expDoneCycle = 0;
  int  totalBits = 0;

  always @(posedge iClock) cyc <= iReset ? 0 : cyc + 1;

  task automatic check(input string name, input longint act, input longint exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every write must match the head of the scoreboard.
  always @(negedge iClock) begin
    if (!iReset) begin
      if (oWrite) begin
        if (sb.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_write: got data 0x%0h at 0x%0h, expected none (cycle %0d)",
                   oSample, oAddress, cyc);
        end else begin
          wr_t e;
          e = sb.pop_front();
          check("wr_data", oSample, e.data);
          check("wr_addr", oAddress, e.addr);
          check("wr_cycle", cyc, e.cyc);
        end
      end
      if (done && doneCycle < 0) doneCycle = cyc;
      if (!done && doneCycle >= 0) check("done_held", done, 1);
    end
  end

  task automatic push_bits(input int v, input int n);
    for (int b = n - 1; b >= 0; b--) bits.push_back(v[b]);
  endtask

  task automatic pack_bits(input logic [15:0] iS);
    for (int w = 0; w < (bits.size() + 15) / 16; w++) begin
      logic [15:0] word;
      word = 16'd0;
      for (int b = 0; b < 16; b++) begin
        if (16 * w + b < bits.size()) word[15 - b] = bits[16 * w + b];
      end
      mem[16'(iS + 16'(w))] = word;
    end
  endtask

  // Reference encoder + decoder model built from the stream format rules.
  task automatic build_case(input int k, input int nS, input logic [15:0] w0,
                            input logic [15:0] w1, input logic [15:0] iS,
                            input logic [15:0] oS);
    logic [15:0] hist[$];
    wr_t e;
    int  nW, c, u, r, q, sn;
    bits.delete();
    plan.delete();
    numSamples    = 16'(nS);
    iAddressStart = iS;
    oAddressStart = oS;
    if (nS == 0) begin
      expDoneCycle = 1;
    end else begin
      push_bits(k, 4);
      nW = (nS < 2) ? nS : 2;
      for (int i = 0; i < nW; i++) begin
        hist.push_back((i == 0) ? w0 : w1);
        push_bits(int'(hist[i]), 16);
        e.addr = 16'(oS + 16'(i));
        e.data = hist[i];
        e.cyc  = 5 + 16 * (i + 1);
        plan.push_back(e);
      end
      c = 5 + 16 * nW;
      for (int j = 0; j < nS - 2; j++) begin
        u = uq[j];
        r = (u % 2 == 0) ? u / 2 : -((u + 1) / 2);
        q = u >> k;
        for (int z = 0; z < q; z++) bits.push_back(1'b0);
        bits.push_back(1'b1);
        push_bits(u & ((1 << k) - 1), k);
        c += q + 1 + k;
        sn = 2 * int'($signed(hist[hist.size() - 1])) - int'($signed(hist[hist.size() - 2])) + r;
        hist.push_back(16'(sn));
        e.addr = 16'(oS + 16'(nW + j));
        e.data = 16'(sn);
        e.cyc  = c;
        plan.push_back(e);
        c += 1;
      end
      expDoneCycle = plan[plan.size() - 1].cyc + 1;
    end
    totalBits = bits.size();
    pack_bits(iS);
  endtask

  task automatic check_reset_values();
    check("rst_iAddress", iAddress, iAddressStart);
    check("rst_oAddress", oAddress, oAddressStart);
    check("rst_oSample", oSample, 0);
    check("rst_oWrite", oWrite, 0);
    check("rst_done", done, 0);
`ifdef FLAC_DEC_ERR_CHECK_EN
    check("rst_oError", oError, 0);
`endif
  endtask

  task automatic run_case(input string name, input int abortAt);
    int n;
    iReset = 1'b1;
    repeat (3) @(posedge iClock);
    #1;
    sb = plan;
    doneCycle = -1;
    check_reset_values();
    iReset = 1'b0;
    if (abortAt > 0) begin
      n = 0;
      while (cyc < abortAt && n < 5000) begin
        @(posedge iClock);
        #1;
        n++;
      end
      iReset = 1'b1;
      @(posedge iClock);
      #1;
      check_reset_values();
      sb = plan;
      doneCycle = -1;
      iReset = 1'b0;
    end
    n = 0;
    while (!done && n < 5000) begin
      @(posedge iClock);
      #1;
      n++;
    end
    if (!done) begin
      total++;
      bad++;
      $display("FAIL %s timeout: done never rose within 5000 cycles", name);
    end
    repeat (4) @(posedge iClock);
    #1;
    check({name, "_leftover"}, sb.size(), 0);
    check({name, "_done_cycle"}, doneCycle, expDoneCycle);
    check({name, "_iAddress"}, iAddress, 16'(iAddressStart + 16'(totalBits / 16)));
    check({name, "_oAddress"}, oAddress, 16'(oAddressStart + 16'(plan.size())));
    check({name, "_done"}, done, 1);
  endtask

  initial begin
    // Nominal stream (encodes to 0x2006, 0x4006, 0x6800).
    uq = {0};
    build_case(2, 3, 16'd100, 16'd102, 16'd0, 16'd0);
    check("nominal_word0", mem[0], 16'h2006);
    check("nominal_word1", mem[1], 16'h4006);
    check("nominal_word2", mem[2], 16'h6800);
    run_case("nominal", 0);

    uq = {5};
    build_case(2, 3, 16'd0, 16'd0, 16'd10, 16'd20);
    check("negative_expect", plan[2].data, 16'hFFFD);
    run_case("negative", 0);

    uq = {2};
    build_case(0, 3, 16'd32767, 16'd32767, 16'd40, 16'd40);
    check("wrap_expect", plan[2].data, 16'h8000);
    run_case("wrap", 0);

    // k=15 residuals straddle word boundaries; address also wraps past 0xFFFF.
    uq = {16'h5A5A, (3 << 15) | 16'h1234, 16'h7FFF};
    build_case(15, 5, 16'hF00D, 16'h0FF0, 16'hFFFE, 16'hFFFD);
    run_case("straddle", 0);

    uq = {};
    build_case(0, 0, 16'd0, 16'd0, 16'd100, 16'd200);
    run_case("zero_samples", 0);

    build_case(3, 1, 16'h8001, 16'd0, 16'd110, 16'd210);
    run_case("one_sample", 0);

    build_case(5, 2, 16'h1234, 16'hFEDC, 16'd120, 16'd220);
    run_case("two_samples", 0);

    uq = {30, 7, 1};
    build_case(0, 5, 16'h0102, 16'h0304, 16'd130, 16'd230);
    run_case("mid_reset", 45);

    for (int t = 0; t < 8; t++) begin
      int k, nS;
      k  = $urandom_range(0, 15);
      nS = $urandom_range(3, 12);
      uq = {};
      for (int j = 0; j < nS - 2; j++) uq.push_back($urandom_range(0, (20 << k) - 1));
      build_case(k, nS, 16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom));
      run_case("random", 0);
    end

`ifdef FLAC_DEC_ERR_CHECK_EN
    uq = {};
    build_case(0, 2, 16'h1111, 16'h2222, 16'd300, 16'd400);
    numSamples = 16'd3;
    for (int z = 0; z < 40; z++) bits.push_back(1'b0);
    pack_bits(16'd300);
    expDoneCycle = 5 + 32 + MAX_Q_TB + 1;
    totalBits    = 36 + MAX_Q_TB + 1;
    run_case("error", 0);
    check("error_flag", oError, 1);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
